// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    DONE
  } dmem_state_e;

  localparam int DMEM_ADDR_W   = 16;
  localparam int DMEM_DATA_W   = 16;
  localparam int DMEM_DEPTH    = 4096;
  localparam int DMEM_READ_LAT = 2;
  localparam int CNT_W         = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write enable and registered read.
module dmem_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Only the output register is cleared; contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the data bus: edge-qualified strobes, fixed read latency.
// Optional host preload port enabled by DMEM_HOST_PORT_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int READ_LAT = DMEM_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_read,
  input  logic              M_write,
  input  logic [ADDR_W-1:0] DATA_ADDRESS_BUS,
  input  logic [DATA_W-1:0] DATA_BUS_out,
  output logic [DATA_W-1:0] DATA_BUS_in,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              addr_err,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_stall
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_lat_chk
    $error("READ_LAT must be within 1..4");
  end

  dmem_state_e state;
  logic req, req_prev, accept, p_ok;
  logic is_wr, oor_q;
  logic [CNT_W-1:0] cnt;

  logic ram_we, ram_re;
  logic [IDX_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign req    = M_read | M_write;
  assign accept = (state == IDLE) && req && !req_prev;
  assign p_ok   = {1'b0, DATA_ADDRESS_BUS} < LIMIT;

`ifdef DMEM_HOST_PORT_EN
  logic host_go, h_ok, h_rd_q, h_oor_q;
  logic [DATA_W-1:0] h_now, h_hold;

  assign h_ok       = {1'b0, host_addr} < LIMIT;
  assign host_go    = host_en && (state == IDLE) && !accept;
  assign host_stall = host_en && !host_go;

  // Processor acceptance always wins the single RAM port.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_idx   = DATA_ADDRESS_BUS[IDX_W-1:0];
    ram_wdata = DATA_BUS_out;
    if (accept) begin
      ram_we = M_write && p_ok;
      ram_re = !M_write;
    end else if (host_go) begin
      ram_idx   = host_addr[IDX_W-1:0];
      ram_wdata = host_wdata;
      ram_we    = host_we && h_ok;
      ram_re    = !host_we;
    end
  end

  assign h_now      = h_oor_q ? '0 : ram_rdata;
  assign host_rdata = h_rd_q ? h_now : h_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_rd_q  <= 1'b0;
      h_oor_q <= 1'b0;
      h_hold  <= '0;
    end else begin
      h_rd_q <= host_go && !host_we;
      if (host_go) h_oor_q <= !h_ok;
      if (h_rd_q)  h_hold  <= h_now;
    end
  end
`else
  logic unused_host;

  assign unused_host = ^{host_en, host_we, host_addr, host_wdata};
  assign host_rdata  = '0;
  assign host_stall  = 1'b0;

  always_comb begin
    ram_we    = accept && M_write && p_ok;
    ram_re    = accept && !M_write;
    ram_idx   = DATA_ADDRESS_BUS[IDX_W-1:0];
    ram_wdata = DATA_BUS_out;
  end
`endif

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Reads pulse ready on entering DONE; writes pulse it on leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_prev    <= 1'b0;
      cnt         <= '0;
      is_wr       <= 1'b0;
      oor_q       <= 1'b0;
      mem_ready   <= 1'b0;
      mem_busy    <= 1'b0;
      addr_err    <= 1'b0;
      DATA_BUS_in <= '0;
    end else begin
      req_prev  <= req;
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_wr    <= M_write;
            oor_q    <= !p_ok;
            mem_busy <= 1'b1;
            if (!p_ok) addr_err <= 1'b1;
            if (M_write) begin
              state <= DONE;
            end else begin
              state <= RD_WAIT;
              cnt   <= CNT_W'(READ_LAT - 1);
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state       <= DONE;
            mem_ready   <= 1'b1;
            DATA_BUS_in <= oor_q ? '0 : ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_busy  <= 1'b0;
          mem_ready <= is_wr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Host checks follow DMEM_HOST_PORT_EN.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_read = 1'b0;
  logic        M_write = 1'b0;
  logic [15:0] DATA_ADDRESS_BUS = '0;
  logic [15:0] DATA_BUS_out = '0;
  logic [15:0] DATA_BUS_in;
  logic        mem_ready, mem_busy, addr_err;
  logic        host_en = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_stall;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .DEPTH    (4096),
    .READ_LAT (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .M_read           (M_read),
    .M_write          (M_write),
    .DATA_ADDRESS_BUS (DATA_ADDRESS_BUS),
    .DATA_BUS_out     (DATA_BUS_out),
    .DATA_BUS_in      (DATA_BUS_in),
    .mem_ready        (mem_ready),
    .mem_busy         (mem_busy),
    .addr_err         (addr_err),
    .host_en          (host_en),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_rdata       (host_rdata),
    .host_stall       (host_stall)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe pulse; lat = edges from acceptance to ready (12 = timeout).
  task automatic proc(input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d,
                      output int lat);
    M_read = rd;
    M_write = wr;
    DATA_ADDRESS_BUS = a;
    DATA_BUS_out = d;
    step(1);
    M_read = 1'b0;
    M_write = 1'b0;
    lat = 0;
    while (!mem_ready && lat < 12) begin
      step(1);
      lat++;
    end
    step(1);
  endtask

  initial begin
    int lat;
    int pulses;
    int n;

    step(2);
    check("rst_data", DATA_BUS_in, 16'h0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_busy", mem_busy, 1'b0);
    check("rst_err", addr_err, 1'b0);
    check("rst_hrdata", host_rdata, 16'h0);
    check("rst_hstall", host_stall, 1'b0);
    rst = 1'b0;
    step(1);

    proc(1'b0, 1'b1, 16'h0000, 16'hBEEF, lat);
    check("wr0_lat", lat, 1);

    // Write: busy right after acceptance, ready one edge later.
    M_write = 1'b1;
    DATA_ADDRESS_BUS = 16'h0010;
    DATA_BUS_out = 16'hA5A5;
    step(1);
    M_write = 1'b0;
    check("wr_busy", mem_busy, 1'b1);
    check("wr_ready_early", mem_ready, 1'b0);
    step(1);
    check("wr_ready", mem_ready, 1'b1);
    check("wr_data_keep", DATA_BUS_in, 16'h0);
    step(1);
    check("wr_ready_drop", mem_ready, 1'b0);

    proc(1'b1, 1'b0, 16'h0010, 16'h0, lat);
    check("rd10_lat", lat, LAT);
    check("rd10_data", DATA_BUS_in, 16'hA5A5);
    check("rd10_idle", mem_busy, 1'b0);

    proc(1'b0, 1'b1, 16'h0020, 16'h5A5A, lat);
    check("wr20_lat", lat, 1);

    // Held strobe gives one pulse; a fresh rise gives another.
    M_read = 1'b1;
    DATA_ADDRESS_BUS = 16'h0020;
    pulses = 0;
    repeat (10) begin
      step(1);
      if (mem_ready) pulses++;
    end
    check("hold_pulses", pulses, 1);
    check("hold_data", DATA_BUS_in, 16'h5A5A);
    M_read = 1'b0;
    step(1);
    M_read = 1'b1;
    pulses = 0;
    repeat (6) begin
      step(1);
      if (mem_ready) pulses++;
    end
    check("rerise_pulses", pulses, 1);
    M_read = 1'b0;
    step(2);

    proc(1'b1, 1'b1, 16'h0030, 16'h1234, lat);
    check("both_lat", lat, 1);
    check("both_data_keep", DATA_BUS_in, 16'h5A5A);
    proc(1'b1, 1'b0, 16'h0030, 16'h0, lat);
    check("rd30_data", DATA_BUS_in, 16'h1234);

`ifdef DMEM_HOST_PORT_EN
    M_read = 1'b1;
    DATA_ADDRESS_BUS = 16'h0030;
    host_en = 1'b1;
    host_we = 1'b1;
    host_addr = 16'h0005;
    host_wdata = 16'h00FF;
    #1;
    check("host_stall_acc", host_stall, 1'b1);
    step(1);
    M_read = 1'b0;
    check("host_stall_busy", host_stall, 1'b1);
    n = 0;
    while (host_stall && n < 10) begin
      step(1);
      n++;
    end
    check("host_retry", host_stall, 1'b0);
    step(1);
    host_we = 1'b0;
    step(1);
    host_en = 1'b0;
    check("host_rd", host_rdata, 16'h00FF);
    step(1);
    check("host_rd_hold", host_rdata, 16'h00FF);
    host_en = 1'b1;
    host_addr = 16'h1000;
    step(1);
    host_en = 1'b0;
    check("host_oor_rd", host_rdata, 16'h0);
    check("host_oor_err", addr_err, 1'b0);
    proc(1'b1, 1'b0, 16'h0005, 16'h0, lat);
    check("rd5_data", DATA_BUS_in, 16'h00FF);
`else
    host_en = 1'b1;
    host_we = 1'b1;
    host_addr = 16'h0005;
    host_wdata = 16'h00FF;
    #1;
    check("host_off_stall", host_stall, 1'b0);
    step(1);
    check("host_off_rdata", host_rdata, 16'h0);
    host_en = 1'b0;
`endif

    // Reset mid-read: outputs clear at once and no ready follows.
    M_read = 1'b1;
    DATA_ADDRESS_BUS = 16'h0010;
    step(1);
    M_read = 1'b0;
    check("mid_busy", mem_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", mem_busy, 1'b0);
    check("mid_rst_data", DATA_BUS_in, 16'h0);
    check("mid_rst_hrdata", host_rdata, 16'h0);
    pulses = 0;
    repeat (3) begin
      step(1);
      if (mem_ready) pulses++;
    end
    check("mid_rst_noready", pulses, 0);
    rst = 1'b0;
    step(1);
    proc(1'b1, 1'b0, 16'h0010, 16'h0, lat);
    check("post_rst_lat", lat, LAT);
    check("post_rst_data", DATA_BUS_in, 16'hA5A5);

    // Out-of-range handling and sticky error flag.
    check("oor_err_pre", addr_err, 1'b0);
    proc(1'b1, 1'b0, 16'h1000, 16'h0, lat);
    check("oor_rd_lat", lat, LAT);
    check("oor_rd_data", DATA_BUS_in, 16'h0);
    check("oor_err_set", addr_err, 1'b1);
    proc(1'b0, 1'b1, 16'h1000, 16'hFFFF, lat);
    check("oor_wr_lat", lat, 1);
    proc(1'b1, 1'b0, 16'h0000, 16'h0, lat);
    check("oor_wr_dropped", DATA_BUS_in, 16'hBEEF);
    check("oor_err_sticky", addr_err, 1'b1);
    rst = 1'b1;
    step(1);
    check("oor_err_clr", addr_err, 1'b0);
    rst = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
